vga_text_render: RTL
====================

VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 Parameter FG_COLOR, default 8'hFF, RGB332 colour for glyph pixels set to 1.
REQ-002 Parameter BG_COLOR, default 8'h00, RGB332 colour for glyph pixels set to 0 and for blanked text area.
REQ-003 clk  input  1  pixel clock, 25 MHz nominal; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 chars  input  8 x [639:0]  character buffer from data memory; index = row*80 + col.
REQ-006 font_char  output  7  glyph code to external combinational font ROM.
REQ-007 font_row  output  4  glyph scanline 0..15 to font ROM.
REQ-008 font_bits  input  8  font ROM row data for (font_char, font_row); bit 7 = leftmost pixel.
REQ-009 hsync  output  1  horizontal sync, active low.
REQ-010 vsync  output  1  vertical sync, active low.
REQ-011 rgb  output  8  RGB332 pixel colour.
REQ-012 video_on  output  1  high while rgb is a visible-area pixel.
REQ-013 frame_start  output  1  one-cycle pulse aligned with pixel (0,0) at the outputs.

Function
REQ-014 Counter hcnt 0..799 increments every clk; wraps 799->0 and then increments vcnt 0..524; vcnt wraps 524->0.
REQ-015 Horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-016 Vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-017 Text area: 80 cols x 8 rows, 8x16 px cells, covering hcnt 0-639, vcnt 0-127; col = hcnt[9:3], row = vcnt[6:4].
REQ-018 Stage 1 (registered): character code = chars[row*80+col]; glyph column hcnt[2:0], scanline vcnt[3:0], text_area flag, visible flag, raw sync levels.
REQ-019 font_char = registered code[6:0]; font_row = registered scanline; both driven from Stage 1 registers.
REQ-020 Stage 2 (registered): pixel bit = font_bits[7 - glyph column]; code bit 7 set inverts the bit (inverse video).
REQ-021 rgb = FG_COLOR if pixel bit 1 and in text area; BG_COLOR if pixel bit 0 in text area or visible but outside text area; 8'h00 outside visible area.
REQ-022 Latency: hsync, vsync, rgb, video_on, frame_start for counter value (h,v) appear exactly 2 clk edges after the counters hold (h,v); all outputs mutually aligned.
REQ-023 Index arithmetic in at least 10 bits; indices 0..639 only; no out-of-range reads.
REQ-024 chars sampled only in Stage 1; a buffer write mid-frame takes effect at the next scan of that cell.
REQ-025 Wrap 799->0 on line 524 produces frame_start for the new (0,0) with no skipped or duplicated pixel.

Reset
REQ-026 On rst assertion, asynchronously: hcnt=0, vcnt=0, pipeline registers cleared, hsync=1, vsync=1, rgb=8'h00, video_on=0, frame_start=0, font_char=0, font_row=0.
REQ-027 After rst deasserts, counters start at (0,0); first frame_start 2 edges after the first counter value (0,0) is captured.
REQ-028 rst asserted mid-frame abandons the frame; restart identical to power-up.

Verification
REQ-029 Free run 2 frames -> hsync low 96 clks per 800-clk line, vsync low 2 lines per 525, frame_start period 420000 clks.
REQ-030 chars[0]=8'h41, font model returns 8'h18 for row 0 -> rgb at pixel (3,0),(4,0) = FG_COLOR, (0..2,0),(5..7,0) = BG_COLOR.
REQ-031 chars[0]=8'hC1 (inverse) with same font -> pixel colours of REQ-030 swapped.
REQ-032 chars[639]=code X, font row 15 = 8'h01 -> only pixel (639,127) = FG_COLOR; font_char=X[6:0], font_row=15 one edge after counters hold (639,127).
REQ-033 Pixel (100,200) and (700,10) -> BG_COLOR with video_on=1 and 8'h00 with video_on=0 respectively.
REQ-034 rst pulsed at (300,250) -> outputs immediately at reset values; after release, next frame_start at 2 edges after (0,0), timing per REQ-029.

Source files
------------

// File: rtl/vga_text_render.sv
// 640x480@60 VGA timing generator with an 80x8 character text overlay (8x16 cells).
// Two-stage pipeline: stage 1 fetches the character code and drives the font ROM, stage 2 forms the pixel.
module vga_text_render #(
   parameter logic [7:0] FG_COLOR = 8'hFF,
   parameter logic [7:0] BG_COLOR = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [639:0][7:0] chars,
   output logic [6:0]       font_char,
   output logic [3:0]       font_row,
   input  logic [7:0]       font_bits,
   output logic             hsync,
   output logic             vsync,
   output logic [7:0]       rgb,
   output logic             video_on,
   output logic             frame_start
);

   localparam logic [9:0] H_VISIBLE    = 10'd640;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd751;
   localparam logic [9:0] H_LAST       = 10'd799;
   localparam logic [9:0] V_VISIBLE    = 10'd480;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd491;
   localparam logic [9:0] V_LAST       = 10'd524;
   localparam logic [9:0] V_TEXT       = 10'd128;
   localparam logic [9:0] COLS         = 10'd80;

   logic [9:0] hcnt;
   logic [9:0] vcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
         hcnt <= hcnt + 10'd1;
      end
   end

   // Stage 0 decode of the current counter position
   logic       h_visible;
   logic       visible;
   logic       text_area;
   logic       hsync_raw;
   logic       vsync_raw;
   logic       origin;
   logic [6:0] col;
   logic [2:0] row;
   logic [9:0] char_index;

   always_comb begin
      h_visible  = (hcnt < H_VISIBLE);
      visible    = h_visible && (vcnt < V_VISIBLE);
      text_area  = h_visible && (vcnt < V_TEXT);
      hsync_raw  = !((hcnt >= H_SYNC_START) && (hcnt <= H_SYNC_END));
      vsync_raw  = !((vcnt >= V_SYNC_START) && (vcnt <= V_SYNC_END));
      origin     = (hcnt == 10'd0) && (vcnt == 10'd0);
      col        = hcnt[9:3];
      row        = vcnt[6:4];
      // Outside the text area col can reach 99; force index 0 so no read leaves 0..639.
      char_index = 10'd0;
      if (text_area) begin
         char_index = 10'(row) * COLS + 10'(col);
      end
   end

   // Stage 1 registers
   logic [7:0] code_reg;
   logic [2:0] gcol_reg;
   logic [3:0] scan_reg;
   logic       text_reg;
   logic       vis_reg;
   logic       hs_reg;
   logic       vs_reg;
   logic       fs_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_reg <= '0;
         gcol_reg <= '0;
         scan_reg <= '0;
         text_reg <= 1'b0;
         vis_reg  <= 1'b0;
         hs_reg   <= 1'b1;
         vs_reg   <= 1'b1;
         fs_reg   <= 1'b0;
      end else begin
         code_reg <= text_area ? chars[char_index] : 8'h00;
         gcol_reg <= hcnt[2:0];
         scan_reg <= vcnt[3:0];
         text_reg <= text_area;
         vis_reg  <= visible;
         hs_reg   <= hsync_raw;
         vs_reg   <= vsync_raw;
         fs_reg   <= origin;
      end
   end

   assign font_char = code_reg[6:0];
   assign font_row  = scan_reg;

   // Code bit 7 selects inverse video for the whole cell
   logic pixel_bit;
   assign pixel_bit = font_bits[3'd7 - gcol_reg] ^ code_reg[7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         rgb         <= 8'h00;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= hs_reg;
         vsync       <= vs_reg;
         video_on    <= vis_reg;
         frame_start <= fs_reg;
         if (text_reg) begin
            rgb <= pixel_bit ? FG_COLOR : BG_COLOR;
         end else if (vis_reg) begin
            rgb <= BG_COLOR;
         end else begin
            rgb <= 8'h00;
         end
      end
   end

endmodule
